// File: rtl/eth_link_seq_if.sv
// Pin bundle between the Ethernet link sequencer and the QSFP module / GT transceiver.
// master = sequencer side, slave = module/transceiver side.
interface eth_link_seq_if;
    logic        qsfp_modprsl;
    logic        gt_reset_tx_done;
    logic        gt_reset_rx_done;
    logic        rx_block_lock;
    logic        rx_high_ber;
    logic        qsfp_resetl;
    logic        gt_reset_all;
    logic        link_up;
    logic [2:0]  state;
    logic [7:0]  retry_count;
    logic [15:0] link_down_count;

    modport master (
        input  qsfp_modprsl, gt_reset_tx_done, gt_reset_rx_done, rx_block_lock, rx_high_ber,
        output qsfp_resetl, gt_reset_all, link_up, state, retry_count, link_down_count
    );

    modport slave (
        output qsfp_modprsl, gt_reset_tx_done, gt_reset_rx_done, rx_block_lock, rx_high_ber,
        input  qsfp_resetl, gt_reset_all, link_up, state, retry_count, link_down_count
    );
endinterface

// File: rtl/eth_link_seq.sv
// QSFP module reset / GT reset / block-lock bring-up sequencer with loss-of-lock recovery.
// Define ETH_LINK_SEQ_STATS_EN to build the retry and link-down statistics counters.
//   state     | meaning
//   IDLE      | module absent, everything held in reset
//   MOD_RST   | qsfp_resetl asserted
//   MOD_INIT  | module released, waiting for it to initialise
//   GT_RST    | gt_reset_all pulse
//   GT_WAIT   | waiting for tx/rx reset done
//   LOCK_WAIT | qualifying block lock
//   LINK_UP   | link running, loss-of-lock filtered
module eth_link_seq #(
    parameter int RESETL_CYCLES      = 1250,
    parameter int MOD_INIT_CYCLES    = 250000,
    parameter int GT_RESET_CYCLES    = 64,
    parameter int TIMEOUT_CYCLES     = 1250000,
    parameter int LOCK_STABLE_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    eth_link_seq_if.master bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOD_RST   = 3'd1,
        MOD_INIT  = 3'd2,
        GT_RST    = 3'd3,
        GT_WAIT   = 3'd4,
        LOCK_WAIT = 3'd5,
        LINK_UP   = 3'd6
    } state_t;

    // Timer counts down to zero, so a state lasting N cycles loads N-1.
    localparam logic [23:0] T_RESETL  = 24'(RESETL_CYCLES - 1);
    localparam logic [23:0] T_INIT    = 24'(MOD_INIT_CYCLES - 1);
    localparam logic [23:0] T_GT_RST  = 24'(GT_RESET_CYCLES - 1);
    localparam logic [23:0] T_TIMEOUT = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0] T_STABLE  = 24'(LOCK_STABLE_CYCLES - 1);

    logic [4:0]  sync1, sync2;
    state_t      state_q, state_next;
    logic [23:0] timer_q, timer_next;
    logic [23:0] win_q, win_next;
    logic        resetl_q, gt_rst_q, link_q;
    logic        modprsl_s, dones_s, good_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.qsfp_modprsl, bus.gt_reset_tx_done, bus.gt_reset_rx_done,
                      bus.rx_block_lock, bus.rx_high_ber};
            sync2 <= sync1;
        end
    end

    assign modprsl_s = sync2[4];
    assign dones_s   = sync2[3] & sync2[2];
    assign good_s    = sync2[1] & ~sync2[0];

    always_comb begin
        state_next = state_q;
        win_next   = win_q;
        timer_next = (timer_q == 24'd0) ? 24'd0 : timer_q - 24'd1;
        case (state_q)
            IDLE:     if (!modprsl_s) state_next = MOD_RST;
            MOD_RST:  if (timer_q == 24'd0) state_next = MOD_INIT;
            MOD_INIT: if (timer_q == 24'd0) state_next = GT_RST;
            GT_RST:   if (timer_q == 24'd0) state_next = GT_WAIT;
            GT_WAIT: begin
                if (dones_s) state_next = LOCK_WAIT;
                else if (timer_q == 24'd0) state_next = GT_RST;
            end
            LOCK_WAIT: begin
                win_next = good_s ? win_q + 24'd1 : 24'd0;
                if (good_s && win_q == T_STABLE) state_next = LINK_UP;
                else if (timer_q == 24'd0) state_next = GT_RST;
            end
            LINK_UP: begin
                win_next = good_s ? 24'd0 : win_q + 24'd1;
                if (!good_s && win_q == T_STABLE) state_next = GT_RST;
            end
            default: state_next = IDLE;
        endcase
        // Losing reset-done drops back to the done wait; module removal beats everything.
        if ((state_q == LOCK_WAIT || state_q == LINK_UP) && !dones_s) state_next = GT_WAIT;
        if (modprsl_s) state_next = IDLE;
        if (state_next != state_q) begin
            win_next = 24'd0;
            case (state_next)
                MOD_RST:   timer_next = T_RESETL;
                MOD_INIT:  timer_next = T_INIT;
                GT_RST:    timer_next = T_GT_RST;
                GT_WAIT:   timer_next = T_TIMEOUT;
                LOCK_WAIT: timer_next = T_TIMEOUT;
                default:   timer_next = 24'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= 24'd0;
            win_q    <= 24'd0;
            resetl_q <= 1'b0;
            gt_rst_q <= 1'b1;
            link_q   <= 1'b0;
        end else begin
            state_q  <= state_next;
            timer_q  <= timer_next;
            win_q    <= win_next;
            resetl_q <= !(state_next == IDLE || state_next == MOD_RST);
            gt_rst_q <= (state_next == IDLE || state_next == MOD_RST ||
                         state_next == MOD_INIT || state_next == GT_RST);
            link_q   <= (state_next == LINK_UP);
        end
    end

    assign bus.state        = state_q;
    assign bus.qsfp_resetl  = resetl_q;
    assign bus.gt_reset_all = gt_rst_q;
    assign bus.link_up      = link_q;

`ifdef ETH_LINK_SEQ_STATS_EN
    logic [7:0]  retry_q;
    logic [15:0] down_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_q <= '0;
            down_q  <= '0;
        end else begin
            if ((state_q == GT_WAIT || state_q == LOCK_WAIT) && state_next == GT_RST &&
                retry_q != 8'hFF)
                retry_q <= retry_q + 8'd1;
            if (state_q == LINK_UP && state_next == GT_RST && down_q != 16'hFFFF)
                down_q <= down_q + 16'd1;
        end
    end

    assign bus.retry_count     = retry_q;
    assign bus.link_down_count = down_q;
`else
    assign bus.retry_count     = '0;
    assign bus.link_down_count = '0;
`endif
endmodule

// File: tb/tb_eth_link_seq.sv
// Directed bench for eth_link_seq with shortened timing parameters.
module tb_eth_link_seq;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

`ifdef ETH_LINK_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    eth_link_seq_if bus();

    eth_link_seq #(
        .RESETL_CYCLES(4), .MOD_INIT_CYCLES(8), .GT_RESET_CYCLES(4),
        .TIMEOUT_CYCLES(20), .LOCK_STABLE_CYCLES(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #4 clk = ~clk;

    typedef struct {
        int         adv;
        logic [2:0] st;
        logic       rl;
        logic       gr;
        logic       lu;
    } vec_t;

    vec_t tbl[10];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [2:0] st, input logic rl,
                           input logic gr, input logic lu);
        chk({name, ".state"}, 32'(bus.state), 32'(st));
        chk({name, ".resetl"}, 32'(bus.qsfp_resetl), 32'(rl));
        chk({name, ".gt_reset_all"}, 32'(bus.gt_reset_all), 32'(gr));
        chk({name, ".link_up"}, 32'(bus.link_up), 32'(lu));
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (bus.state != s && n < budget) begin
            step(1);
            n++;
        end
        chk(name, 32'(bus.state), 32'(s));
    endtask

    initial begin
        // adv = edges after the previous record (first: after modprsl falls)
        tbl[0] = '{3, 3'd1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{3, 3'd1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{7, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{3, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{4, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1, 3'd6, 1'b1, 1'b0, 1'b1};

        rst                  = 1'b1;
        bus.qsfp_modprsl     = 1'b1;
        bus.gt_reset_tx_done = 1'b1;
        bus.gt_reset_rx_done = 1'b1;
        bus.rx_block_lock    = 1'b1;
        bus.rx_high_ber      = 1'b0;
        step(3);
        chk_out("reset", 3'd0, 1'b0, 1'b1, 1'b0);
        chk("reset.retry", 32'(bus.retry_count), 0);
        chk("reset.down", 32'(bus.link_down_count), 0);

        rst = 1'b0;
        step(5);
        chk("absent_idle", 32'(bus.state), 0);

        // Nominal bring-up
        bus.qsfp_modprsl = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].adv);
            chk_out($sformatf("bringup%0d", i), tbl[i].st, tbl[i].rl, tbl[i].gr, tbl[i].lu);
        end

        // Loss-of-lock shorter than the filter is ignored
        bus.rx_block_lock = 1'b0;
        step(4);
        bus.rx_block_lock = 1'b1;
        step(6);
        chk_out("glitch4", 3'd6, 1'b1, 1'b0, 1'b1);

        // Loss-of-lock for the full filter length
        bus.rx_block_lock = 1'b0;
        step(5);
        bus.rx_block_lock = 1'b1;
        step(1);
        chk_out("glitch5_pre", 3'd6, 1'b1, 1'b0, 1'b1);
        step(1);
        chk_out("glitch5", 3'd3, 1'b1, 1'b1, 1'b0);
        chk("glitch5.down", 32'(bus.link_down_count), STATS ? 1 : 0);

        wait_state(3'd6, 60, "relock");

        // Reset-done drop in LINK_UP returns to GT_WAIT without counting
        bus.gt_reset_tx_done = 1'b0;
        step(2);
        chk("done_drop_pre", 32'(bus.state), 6);
        step(1);
        chk_out("done_drop", 3'd4, 1'b1, 1'b0, 1'b0);
        chk("done_drop.down", 32'(bus.link_down_count), STATS ? 1 : 0);
        chk("done_drop.retry", 32'(bus.retry_count), 0);

        // GT_WAIT timeout after 20 cycles
        step(19);
        chk("gtwait_last", 32'(bus.state), 4);
        step(1);
        chk("gtwait_timeout", 32'(bus.state), 3);
        chk("gtwait_timeout.retry", 32'(bus.retry_count), STATS ? 1 : 0);

        // LOCK_WAIT timeout with no lock
        bus.gt_reset_tx_done = 1'b1;
        bus.rx_block_lock    = 1'b0;
        wait_state(3'd5, 40, "lockwait_enter");
        step(19);
        chk("lockwait_last", 32'(bus.state), 5);
        step(1);
        chk("lockwait_timeout", 32'(bus.state), 3);
        chk("lockwait_timeout.retry", 32'(bus.retry_count), STATS ? 2 : 0);

        // Retry saturation
        bus.gt_reset_tx_done = 1'b0;
        for (int i = 0; i < 253; i++) begin
            wait_state(3'd4, 60, "sat_gtwait");
            wait_state(3'd3, 60, "sat_gtrst");
        end
        chk("retry_at_max", 32'(bus.retry_count), STATS ? 255 : 0);
        for (int i = 0; i < 47; i++) begin
            wait_state(3'd4, 60, "sat2_gtwait");
            wait_state(3'd3, 60, "sat2_gtrst");
        end
        chk("retry_saturated", 32'(bus.retry_count), STATS ? 255 : 0);

        // Module removal during GT_WAIT
        wait_state(3'd4, 60, "remove_gtwait");
        bus.qsfp_modprsl = 1'b1;
        step(2);
        chk("remove_pre", 32'(bus.state), 4);
        step(1);
        chk_out("remove", 3'd0, 1'b0, 1'b1, 1'b0);

        // Synchronous reset from LINK_UP
        bus.qsfp_modprsl     = 1'b0;
        bus.gt_reset_tx_done = 1'b1;
        bus.rx_block_lock    = 1'b1;
        wait_state(3'd6, 100, "relink");
        rst = 1'b1;
        step(1);
        chk_out("midrst", 3'd0, 1'b0, 1'b1, 1'b0);
        chk("midrst.retry", 32'(bus.retry_count), 0);
        chk("midrst.down", 32'(bus.link_down_count), 0);
        rst = 1'b0;
        step(3);
        chk("post_rst.retry", 32'(bus.retry_count), 0);
        chk("post_rst.down", 32'(bus.link_down_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eth_link_seq.md
ETH_LINK_SEQ -- requirements
Module: eth_link_seq

Interface
REQ-001 SHALL have parameter RESETL_CYCLES, default 1250, meaning cycles qsfp_resetl held low.
REQ-002 SHALL have parameter MOD_INIT_CYCLES, default 250000, meaning wait after module reset release.
REQ-003 SHALL have parameter GT_RESET_CYCLES, default 64, meaning cycles gt_reset_all held high.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1250000, meaning limit for reset-done and block-lock waits.
REQ-005 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, meaning lock-qualification window and loss-of-lock filter.
REQ-006 SHALL have ports: clk  in  1  free-running 125 MHz clock; all logic on rising edge.
REQ-007 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports: qsfp_modprsl  in  1  module present, active low, asynchronous.
REQ-009 SHALL have ports: gt_reset_tx_done, gt_reset_rx_done, rx_block_lock, rx_high_ber  in  1 each  asynchronous status.
REQ-010 SHALL have ports: qsfp_resetl  out  1  module reset, active low.
REQ-011 SHALL have ports: gt_reset_all  out  1  GT full reset request.
REQ-012 SHALL have ports: link_up  out 1; state  out 3; retry_count  out 8; link_down_count  out 16.

Function
REQ-013 SHALL pass every asynchronous input through a 2-flop synchronizer; FSM sees a pin change 2 cycles later.
REQ-014 SHALL use one 24-bit down-counter timer, loaded on every state entry; parameters exceeding 2^24-1 are illegal.
REQ-015 SHALL implement states IDLE=0, MOD_RST=1, MOD_INIT=2, GT_RST=3, GT_WAIT=4, LOCK_WAIT=5, LINK_UP=6; state output equals encoding.
REQ-016 IDLE: qsfp_resetl=0, gt_reset_all=1; synchronized modprsl=0 -> MOD_RST.
REQ-017 MOD_RST: qsfp_resetl=0 for exactly RESETL_CYCLES cycles -> MOD_INIT.
REQ-018 MOD_INIT: qsfp_resetl=1, gt_reset_all=1 for MOD_INIT_CYCLES cycles -> GT_RST.
REQ-019 GT_RST: gt_reset_all=1 for exactly GT_RESET_CYCLES cycles -> GT_WAIT.
REQ-020 GT_WAIT: gt_reset_all=0; tx_done and rx_done both 1 -> LOCK_WAIT; timer expiry first -> GT_RST, retry_count+1.
REQ-021 LOCK_WAIT: block_lock=1 and high_ber=0 for LOCK_STABLE_CYCLES consecutive cycles -> LINK_UP; any violation restarts the window; TIMEOUT_CYCLES elapsed in state -> GT_RST, retry_count+1.
REQ-022 LINK_UP: link_up=1 registered, asserted first cycle in state; block_lock=0 or high_ber=1 for LOCK_STABLE_CYCLES consecutive cycles -> GT_RST, link_down_count+1; shorter glitches ignored.
REQ-023 Module removal (synchronized modprsl=1) from any state SHALL force IDLE next cycle, overriding all other transitions.
REQ-024 gt_reset_tx_done or rx_done dropping in LOCK_WAIT or LINK_UP SHALL -> GT_WAIT with timer reloaded, no counter change.
REQ-025 retry_count and link_down_count SHALL saturate at all-ones, never wrap; both clear only on rst.
REQ-026 link_up SHALL be 1 only in LINK_UP.

Reset
REQ-027 On rst: state=IDLE, qsfp_resetl=0, gt_reset_all=1, link_up=0, counters=0, timer=0, synchronizers=0 (module treated as present until resampled).
REQ-028 rst asserted mid-sequence SHALL take effect next edge regardless of state; outputs reach reset values that cycle.

Configuration
REQ-029 Macro ETH_LINK_SEQ_STATS_EN: defined -> retry_count and link_down_count implemented per REQ-020..025.
REQ-030 Without ETH_LINK_SEQ_STATS_EN: both outputs tied to 0, counter registers absent; FSM behaviour unchanged.

Verification (RESETL=4, MOD_INIT=8, GT_RESET=4, TIMEOUT=20, LOCK_STABLE=5)
REQ-031 modprsl 1->0, done=1, lock=1 steady -> resetl low 4 cycles, gt_reset_all falls after 8+4 cycles, link_up rises 5 cycles after LOCK_WAIT entry.
REQ-032 done held 0 -> GT_WAIT times out after 20 cycles, re-enters GT_RST, retry_count=1; repeat 300 times -> retry_count=255.
REQ-033 In LINK_UP, lock=0 for 4 cycles -> link_up stays 1; lock=0 for 5 cycles -> GT_RST, link_down_count=1.
REQ-034 modprsl=1 during GT_WAIT -> IDLE 3 cycles after pin edge, gt_reset_all=1, resetl=0.
REQ-035 rst pulsed in LINK_UP -> next cycle state=0, link_up=0, counters=0; without macro counters read 0 throughout.
